// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches each 32-bit instruction as two ROM words, decodes its class
// and drives the bus-unit transaction sequence over a busy/ready handshake guarded by a watchdog.
module instr_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        biu_ready,
    input  logic [15:0] biu_data,
    output logic        biu_cs,
    output logic [1:0]  biu_sel,
    output logic [1:0]  biu_sel_eu,
    output logic [1:0]  biu_op_sel,
    output logic [31:0] ir,
    output logic [15:0] fetch_address,
    output logic [15:0] pc,
    output logic        halted,
    output logic        error
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [1:0] SEL_MOV    = 2'b00;
    localparam logic [1:0] SEL_LS     = 2'b01;
    localparam logic [1:0] SEL_EXEC   = 2'b10;
    localparam logic [1:0] SEL_FETCH  = 2'b11;
    localparam logic [1:0] EU_ARITH_I = 2'b00;
    localparam logic [1:0] EU_COMPARE = 2'b10;
    localparam logic [1:0] EU_BAD     = 2'b11;
    localparam logic [1:0] OP_1       = 2'b00;
    localparam logic [1:0] OP_2       = 2'b01;
    localparam logic [1:0] OP_RES     = 2'b10;

    typedef enum logic [3:0] {
        IDLE,
        ISSUE_FHI,
        WAIT_FHI,
        ISSUE_FLO,
        WAIT_FLO,
        DECODE,
        ISSUE_X,
        WAIT_X,
        HALT,
        ERROR
    } state_t;

    state_t          state, state_nx;
    logic            busy_seen, busy_seen_nx;
    logic [WD_W-1:0] wd, wd_nx;
    logic            cs_nx;
    logic [1:0]      sel_nx, eu_nx, op_nx;
    logic [31:0]     ir_nx;
    logic [15:0]     fa_nx, pc_nx;
    logic            wait_st, done, last_step;
    logic [1:0]      op_step;
    state_t          end_state;

    assign wait_st   = (state == WAIT_FHI) || (state == WAIT_FLO) || (state == WAIT_X);
    // A transaction is done only once busy has been observed; an early ready is the idle level.
    assign done      = wait_st && busy_seen && biu_ready;
    assign end_state = run ? ISSUE_FHI : IDLE;

    // Execute step order: arith_i 00,10; arith 00,01,10; compare 00,01.
    assign last_step = (biu_sel != SEL_EXEC) || (biu_op_sel == OP_RES) ||
                       ((biu_sel_eu == EU_COMPARE) && (biu_op_sel == OP_2));
    assign op_step   = ((biu_op_sel == OP_1) && (biu_sel_eu != EU_ARITH_I)) ? OP_2 : OP_RES;

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        state_nx     = state;
        busy_seen_nx = busy_seen;
        wd_nx        = wd;
        cs_nx        = 1'b0;
        sel_nx       = biu_sel;
        eu_nx        = biu_sel_eu;
        op_nx        = biu_op_sel;
        ir_nx        = ir;
        fa_nx        = fetch_address;
        pc_nx        = pc;

        if (wait_st) begin
            if (!biu_ready) busy_seen_nx = 1'b1;
            if (!done) begin
                if (wd == WD_LAST) state_nx = ERROR;
                else               wd_nx    = wd + 1'b1;
            end
        end

        case (state)
            IDLE: if (run) state_nx = ISSUE_FHI;
            ISSUE_FHI, ISSUE_FLO, ISSUE_X: begin
                if (biu_ready) begin
                    cs_nx        = 1'b1;
                    busy_seen_nx = 1'b0;
                    wd_nx        = '0;
                    if (state == ISSUE_FHI) begin
                        sel_nx   = SEL_FETCH;
                        fa_nx    = pc;
                        state_nx = WAIT_FHI;
                    end else if (state == ISSUE_FLO) begin
                        sel_nx   = SEL_FETCH;
                        fa_nx    = pc + 16'd1;
                        state_nx = WAIT_FLO;
                    end else begin
                        state_nx = WAIT_X;
                    end
                end
            end
            WAIT_FHI: if (done) begin
                ir_nx[31:16] = biu_data;
                state_nx     = ISSUE_FLO;
            end
            WAIT_FLO: if (done) begin
                ir_nx[15:0] = biu_data;
                pc_nx       = pc + 16'd2;
                state_nx    = DECODE;
            end
            DECODE: begin
                case (ir[21:20])
                    2'b00: begin
                        sel_nx   = SEL_MOV;
                        state_nx = ISSUE_X;
                    end
                    2'b01: begin
                        sel_nx   = SEL_LS;
                        state_nx = ISSUE_X;
                    end
                    2'b10: begin
                        if (ir[23:22] == EU_BAD) begin
                            state_nx = ERROR;
                        end else begin
                            sel_nx   = SEL_EXEC;
                            eu_nx    = ir[23:22];
                            op_nx    = OP_1;
                            state_nx = ISSUE_X;
                        end
                    end
                    default: state_nx = HALT;
                endcase
            end
            WAIT_X: if (done) begin
                if (last_step) begin
                    state_nx = end_state;
                end else begin
                    op_nx    = op_step;
                    state_nx = ISSUE_X;
                end
            end
            HALT:    state_nx = HALT;
            ERROR:   state_nx = ERROR;
            default: state_nx = ERROR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so each register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy_seen     <= 1'b0;
            wd            <= '0;
            biu_cs        <= 1'b0;
            biu_sel       <= 2'b00;
            biu_sel_eu    <= 2'b00;
            biu_op_sel    <= 2'b00;
            ir            <= '0;
            fetch_address <= '0;
            pc            <= RESET_PC;
            halted        <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_nx;
            busy_seen     <= busy_seen_nx;
            wd            <= wd_nx;
            biu_cs        <= cs_nx;
            biu_sel       <= sel_nx;
            biu_sel_eu    <= eu_nx;
            biu_op_sel    <= op_nx;
            ir            <= ir_nx;
            fetch_address <= fa_nx;
            pc            <= pc_nx;
            halted        <= (state_nx == HALT);
            error         <= (state_nx == ERROR);
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a randomized-latency bus-unit responder logs every cs strobe and the log
// is compared against a transaction list derived from the ROM program by an instruction-level model.
module tb_instr_sequencer;
    localparam logic [15:0] RESET_PC = 16'hFFFE;
    localparam int          TIMEOUT  = 64;

    typedef struct packed {
        logic [1:0]  sel;
        logic [1:0]  eu;
        logic [1:0]  op;
        logic [15:0] fa;
        logic [15:0] pc;
        logic [31:0] ir;
    } txn_t;

    logic        clk, rst_n, run, biu_ready;
    logic [15:0] biu_data;
    logic        biu_cs;
    logic [1:0]  biu_sel, biu_sel_eu, biu_op_sel;
    logic [31:0] ir;
    logic [15:0] fetch_address, pc;
    logic        halted, error;

    instr_sequencer #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .biu_ready(biu_ready), .biu_data(biu_data),
        .biu_cs(biu_cs), .biu_sel(biu_sel), .biu_sel_eu(biu_sel_eu), .biu_op_sel(biu_op_sel),
        .ir(ir), .fetch_address(fetch_address), .pc(pc), .halted(halted), .error(error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [15:0] rom [0:65535];
    txn_t        obs_q[$];
    txn_t        exp_q[$];
    bit          stall;
    int          hold_err;
    int          n_assert, n_fail;
    logic [15:0] m_pc;
    logic [31:0] m_ir;
    bit          m_halt, m_err;

    function automatic txn_t mk_txn(input logic [1:0] sel, input logic [1:0] eu, input logic [1:0] op,
                                    input logic [15:0] fa, input logic [15:0] pcv, input logic [31:0] irv);
        txn_t t;
        t.sel = sel; t.eu = eu; t.op = op; t.fa = fa; t.pc = pcv; t.ir = irv;
        return t;
    endfunction

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Bus unit: busy for a random time after each cs, sometimes one cycle late to drop ready.
    initial begin : biu_model
        int   busy_left;
        bit   drop_pending;
        txn_t cur;
        busy_left = 0; drop_pending = 0; cur = '0;
        biu_ready = 1'b1; biu_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_left = 0; drop_pending = 0; biu_ready = 1'b1;
                continue;
            end
            if ((busy_left > 0 || drop_pending) && (biu_sel !== cur.sel ||
                (cur.sel == 2'b10 && (biu_sel_eu !== cur.eu || biu_op_sel !== cur.op))))
                hold_err++;
            if (biu_cs) begin
                cur = mk_txn(biu_sel, (biu_sel == 2'b10) ? biu_sel_eu : 2'b00,
                             (biu_sel == 2'b10) ? biu_op_sel : 2'b00,
                             (biu_sel == 2'b11) ? fetch_address : 16'h0000, pc, ir);
                obs_q.push_back(cur);
                busy_left    = $urandom_range(1, 4);
                drop_pending = ($urandom_range(0, 1) == 1);
                if (!drop_pending) biu_ready = 1'b0;
            end else if (drop_pending) begin
                drop_pending = 0;
                biu_ready    = 1'b0;
            end else if (busy_left > 0 && !stall) begin
                busy_left--;
                if (busy_left == 0) begin
                    biu_ready = 1'b1;
                    biu_data  = (cur.sel == 2'b11) ? rom[fetch_address] : 16'($urandom);
                end
            end
        end
    end

    // Instruction-level reference: walks the ROM program and lists every transaction it implies.
    task automatic model_run(input int max_instr);
        logic [15:0] hi, lo, a1;
        logic [1:0]  eu;
        exp_q.delete();
        m_pc = RESET_PC; m_ir = '0; m_halt = 0; m_err = 0;
        for (int n = 0; n < max_instr && !m_halt && !m_err; n++) begin
            a1 = m_pc + 16'd1;
            hi = rom[m_pc];
            lo = rom[a1];
            exp_q.push_back(mk_txn(2'b11, 2'b00, 2'b00, m_pc, m_pc, m_ir));
            exp_q.push_back(mk_txn(2'b11, 2'b00, 2'b00, a1, m_pc, {hi, m_ir[15:0]}));
            m_ir = {hi, lo};
            m_pc = m_pc + 16'd2;
            eu   = m_ir[23:22];
            case (m_ir[21:20])
                2'b00, 2'b01: exp_q.push_back(mk_txn(m_ir[21:20], 2'b00, 2'b00, 16'h0000, m_pc, m_ir));
                2'b10: begin
                    if (eu == 2'b11) m_err = 1;
                    else
                        for (int op = 0; op < 3; op++)
                            if (!(op == 1 && eu == 2'b00) && !(op == 2 && eu == 2'b10))
                                exp_q.push_back(mk_txn(2'b10, eu, 2'(op), 16'h0000, m_pc, m_ir));
                end
                default: m_halt = 1;
            endcase
        end
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_count"}, 128'(obs_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s_txn%0d", tag, i), 128'(obs_q[i]), 128'(exp_q[i]));
        check({tag, "_pc"}, 128'(pc), 128'(m_pc));
        check({tag, "_ir"}, 128'(ir), 128'(m_ir));
        check({tag, "_halted"}, 128'(halted), 128'(m_halt));
        check({tag, "_error"}, 128'(error), 128'(m_err));
        check({tag, "_sel_hold"}, 128'(hold_err), 128'(0));
    endtask

    task automatic hold_reset(input string tag);
        int cs_seen;
        cs_seen = 0;
        @(negedge clk);
        rst_n = 1'b0; run = 1'b1; stall = 0;
        repeat (4) begin
            @(negedge clk);
            if (biu_cs !== 1'b0) cs_seen++;
        end
        obs_q.delete();
        hold_err = 0;
        check({tag, "_rst_cs"}, 128'(cs_seen), 128'(0));
        check({tag, "_rst_pc"}, 128'(pc), 128'(RESET_PC));
        check({tag, "_rst_ir"}, 128'(ir), 128'(0));
        check({tag, "_rst_fa"}, 128'(fetch_address), 128'(0));
        check({tag, "_rst_sel"}, 128'({biu_sel, biu_sel_eu, biu_op_sel}), 128'(0));
        check({tag, "_rst_flags"}, 128'({halted, error}), 128'(0));
        for (int k = 0; k < 64; k++) rom[RESET_PC + 16'(k)] = '0;
    endtask

    task automatic load_instr(input int idx, input logic [15:0] hi, input logic [15:0] lo);
        rom[RESET_PC + 16'(2 * idx)]     = hi;
        rom[RESET_PC + 16'(2 * idx + 1)] = lo;
    endtask

    function automatic logic [15:0] rand_hi(input logic [1:0] cls, input logic [1:0] eu);
        logic [15:0] w;
        w      = 16'($urandom);
        w[5:4] = cls;
        w[7:6] = eu;
        return w;
    endfunction

    task automatic wait_stop(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while (!(halted || error) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_stop_in_time"}, 128'(cyc < budget), 128'(1));
        repeat (20) @(negedge clk);
    endtask

    initial begin : stimulus
        int cyc;
        n_assert = 0; n_fail = 0; hold_err = 0;
        rst_n = 1'b0; run = 1'b0; stall = 0;
        for (int i = 0; i < 65536; i++) rom[i] = '0;

        // Directed program starting at FFFE: wrap, mov-imm, arith, compare, arith_i, halt.
        hold_reset("dir");
        load_instr(0, 16'h0010, 16'hBEEF);
        load_instr(1, 16'h0008, 16'h1234);
        load_instr(2, 16'h0060, 16'h5A5A);
        load_instr(3, 16'h00A0, 16'h0001);
        load_instr(4, 16'h0020, 16'h0002);
        load_instr(5, 16'h0030, 16'h0000);
        model_run(100);
        @(negedge clk) rst_n = 1'b1;
        wait_stop("dir", 3000);
        compare_log("dir");
        if (obs_q.size() > 5) begin
            check("dir_wrap_fa0", 128'(obs_q[0].fa), 128'(16'hFFFE));
            check("dir_wrap_fa1", 128'(obs_q[1].fa), 128'(16'hFFFF));
            check("dir_wrap_fa2", 128'(obs_q[3].fa), 128'(16'h0000));
            check("dir_mov_ir", 128'(obs_q[5].ir), 128'(32'h00081234));
            check("dir_mov_pc", 128'(obs_q[5].pc), 128'(16'h0002));
            check("dir_mov_sel", 128'(obs_q[5].sel), 128'(2'b00));
        end

        // Random programs ending in halt.
        for (int r = 0; r < 3; r++) begin
            hold_reset($sformatf("rnd%0d", r));
            for (int k = 0; k < 10; k++) begin
                logic [1:0] cls;
                cls = 2'($urandom_range(0, 2));
                load_instr(k, rand_hi(cls, 2'($urandom_range(0, 2))), 16'($urandom));
            end
            load_instr(10, rand_hi(2'b11, 2'($urandom_range(0, 3))), 16'($urandom));
            model_run(100);
            @(negedge clk) rst_n = 1'b1;
            wait_stop($sformatf("rnd%0d", r), 5000);
            compare_log($sformatf("rnd%0d", r));
        end

        // Illegal execute unit 11 after one mov.
        hold_reset("ill");
        load_instr(0, 16'h0000, 16'h0000);
        load_instr(1, 16'h00E0, 16'h1111);
        model_run(100);
        @(negedge clk) rst_n = 1'b1;
        wait_stop("ill", 1000);
        compare_log("ill");
        check("ill_error_set", 128'(error), 128'(1));

        // Bus stuck busy: watchdog must raise error around TIMEOUT cycles after cs.
        hold_reset("wd");
        stall = 1;
        @(negedge clk) rst_n = 1'b1;
        cyc = 0;
        while (obs_q.size() == 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("wd_first_cs", 128'(obs_q.size()), 128'(1));
        repeat (TIMEOUT - 4) @(negedge clk);
        check("wd_not_early", 128'(error), 128'(0));
        repeat (8) @(negedge clk);
        check("wd_error", 128'(error), 128'(1));
        repeat (10) @(negedge clk);
        check("wd_error_sticky", 128'(error), 128'(1));
        check("wd_no_more_cs", 128'(obs_q.size()), 128'(1));

        // run dropped during the first arith step: all three steps finish, then stop.
        hold_reset("stop");
        load_instr(0, 16'h0060, 16'h7777);
        load_instr(1, 16'h0000, 16'h0000);
        @(negedge clk) rst_n = 1'b1;
        cyc = 0;
        while (obs_q.size() < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("stop_reached_exec", 128'(obs_q.size() >= 3), 128'(1));
        run = 1'b0;
        repeat (60) @(negedge clk);
        model_run(1);
        compare_log("stop");
        run = 1'b1;
        cyc = 0;
        while (obs_q.size() < 6 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("resume_seen", 128'(obs_q.size() >= 6), 128'(1));
        if (obs_q.size() >= 6) check("resume_fa", 128'(obs_q[5].fa), 128'(m_pc));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
